// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Used by both the TX and RX blocks.
package uart_tx_pkg;
    localparam int NB_DATA_DEF = 8;
    localparam int OVS_DEF     = 16;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Counter width; never below one bit so degenerate sizes still elaborate
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// Host-side request/status bundle for uart_tx.
interface uart_tx_if import uart_tx_pkg::*; #(parameter int NB_DATA = NB_DATA_DEF) ();
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_tx_data;
    logic               o_tx_busy;
    logic               o_tx_done;

    modport master (output i_tx_start, i_tx_data, input  o_tx_busy, o_tx_done);
    modport slave  (input  i_tx_start, i_tx_data, output o_tx_busy, o_tx_done);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Modulo-N baud tick generator; one instance feeds both UART TX and RX.
module baud_gen #(
    parameter int N = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign o_tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx import uart_tx_pkg::*; #(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OVS     = OVS_DEF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tick,
    output logic       o_tx,
    uart_tx_if.slave   bus
);
    localparam int BW = cnt_w(NB_DATA);
    localparam int TW = cnt_w((OVS > SB_TICK) ? OVS : SB_TICK);
    localparam logic [TW-1:0] OVS_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

    uart_state_e        state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: if (bus.i_tx_start) begin
                state_d = ST_START;
                shreg_d = bus.i_tx_data;
                tick_d  = '0;
                bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                par_d   = ^bus.i_tx_data;
`endif
            end
            ST_START: if (i_tick) begin
                if (tick_q == OVS_LAST) begin
                    state_d = ST_DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end else tick_d = tick_q + 1'b1;
            end
            ST_DATA: if (i_tick) begin
                if (tick_q == OVS_LAST) begin
                    tick_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else bit_d = bit_q + 1'b1;
                end else tick_d = tick_q + 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (i_tick) begin
                if (tick_q == OVS_LAST) begin
                    state_d = ST_STOP;
                    tick_d  = '0;
                end else tick_d = tick_q + 1'b1;
            end
`endif
            ST_STOP: if (i_tick) begin
                if (tick_q == SB_LAST) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end else tick_d = tick_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is decoded from the next state so the flop changes on the same edge as the FSM
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign o_tx          = tx_q;
    assign bus.o_tx_done = done_q;
    assign bus.o_tx_busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx driven by baud_gen (tick every 4 clocks).
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int NB  = 8;
    localparam int OVS = 16;
    localparam int SBT = 16;
    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FT = (1 + NB + P) * OVS + SBT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gen_tick, tick_g, tx;
    logic tick_en = 1'b1;

    assign tick_g = gen_tick & tick_en;

    uart_tx_if #(.NB_DATA(NB)) bus ();

    baud_gen #(.N(DIV)) u_bg (.i_clock(clk), .i_reset(rst), .o_tick(gen_tick));

    uart_tx #(.NB_DATA(NB), .SB_TICK(SBT), .OVS(OVS)) dut (
        .i_clock(clk), .i_reset(rst), .i_tick(tick_g), .o_tx(tx), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic clk_log[$];
    logic tk_log[$];
    int   done_cnt;
    int   done_at;
    bit   pre_started = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference line level for tick-slot i of a frame carrying d
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int slot = i / OVS;
        if (slot == 0) return 1'b0;
        if (slot <= NB) return d[slot-1];
        if (P == 1 && slot == NB + 1) return ^d;
        return 1'b1;
    endfunction

    // One frame: accept, sample per clock and per tick, optional mid-frame disturbances
    task automatic run_frame(input logic [7:0] d, input int mid_at, input int frz_at,
                             input int rst_at, input bit chain, input logic [7:0] nd);
        bit   seen = 0;
        int   post = 0;
        int   mism = 0;
        logic exp_frz = 1'b1;
        logic [7:0] dec;
        clk_log.delete(); tk_log.delete();
        done_cnt = 0; done_at = -1;
        if (!pre_started) begin
            @(negedge clk);
            for (int k = 0; k < DIV && !gen_tick; k++) @(negedge clk);
            chk("align", gen_tick, 1);
            bus.i_tx_start = 1'b1;
            bus.i_tx_data  = d;
        end
        pre_started = 0;
        @(negedge clk);
        bus.i_tx_start = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (n > 0) @(negedge clk);
            if (!seen) begin
                clk_log.push_back(tx);
                if (tick_g) tk_log.push_back(tx);
            end
            if (bus.o_tx_done) begin
                done_cnt++;
                if (!seen) done_at = n;
                seen = 1;
            end
            if (n == mid_at) begin bus.i_tx_start = 1'b1; bus.i_tx_data = 8'hFF; end
            if (n == mid_at + 1) bus.i_tx_start = 1'b0;
            if (n == frz_at) begin exp_frz = d[tk_log.size()/OVS - 1]; tick_en = 1'b0; end
            if (frz_at >= 0 && n == frz_at + 50) begin chk("frz_tx", tx, exp_frz); tick_en = 1'b1; end
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_tx", tx, 1);
                chk("rst_busy", bus.o_tx_busy, 0);
                chk("rst_done", bus.o_tx_done, 0);
                rst = 1'b0;
                done_cnt = 0;
                for (int k = 0; k < 800; k++) begin
                    @(negedge clk);
                    if (bus.o_tx_done) done_cnt++;
                end
                chk("rst_nodone", done_cnt, 0);
                return;
            end
            if (seen) begin
                if (chain) begin
                    bus.i_tx_start = 1'b1;
                    bus.i_tx_data  = nd;
                    pre_started = 1;
                    break;
                end
                post++;
                if (post > 8) break;
            end
        end
        chk("done_seen", seen, 1);
        chk("done_cnt", done_cnt, 1);
        chk("len", tk_log.size(), FT);
        for (int i = 0; i < tk_log.size(); i++)
            if (tk_log[i] !== exp_bit(d, i)) mism++;
        chk("stream", mism, 0);
        dec = '0;
        if (tk_log.size() >= OVS * (NB + 1))
            for (int b = 0; b < NB; b++) dec[b] = tk_log[OVS*(1+b) + OVS/2];
        chk("data", dec, d);
    endtask

    initial begin
        int a5_seq[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
        int m, ones;
        bus.i_tx_start = 1'b0;
        bus.i_tx_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx0", tx, 1);
        chk("rst_busy0", bus.o_tx_busy, 0);
        chk("rst_done0", bus.o_tx_done, 0);
        rst = 1'b0;

        // 0xA5: each bit 64 clocks, done FT*DIV clocks after accept
        run_frame(8'hA5, -1, -1, -1, 0, 8'h00);
        chk("a5_done_at", done_at, FT * DIV);
        for (int k = 0; k < 9; k++)
            if (clk_log.size() > 64*k + 32) chk("a5_bit", clk_log[64*k + 32], a5_seq[k]);
        m = 0;
        for (int i = 0; i < clk_log.size() && i < FT * DIV; i++)
            if (clk_log[i] !== exp_bit(8'hA5, i / DIV)) m++;
        chk("a5_clk_stream", m, 0);

        // Second start 100 clocks into 0x3C must be ignored
        run_frame(8'h3C, 100, -1, -1, 0, 8'h00);

        // 0x0F then 0x55 accepted in the done cycle
        run_frame(8'h0F, -1, -1, -1, 1, 8'h55);
        ones = 0;
        for (int i = clk_log.size() - 1; i >= 0 && clk_log[i] === 1'b1; i--) ones++;
        chk("gap", ones, SBT * DIV + 1);
        run_frame(8'h55, -1, -1, -1, 0, 8'h00);
        chk("b2b_start", clk_log[0], 0);

        // Reset during data bit 3, then a clean frame
        run_frame(8'h81, -1, -1, 280, 0, 8'h00);
        run_frame(8'h81, -1, -1, -1, 0, 8'h00);

        // Tick stalled for 50 clocks inside data bit 1
        run_frame(8'hC3, -1, 150, -1, 0, 8'h00);

`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, -1, -1, -1, 0, 8'h00);
        chk("par_07", tk_log[OVS*9 + OVS/2], 1);
        chk("par_len", tk_log.size(), 11 * OVS);
        run_frame(8'h03, -1, -1, -1, 0, 8'h00);
        chk("par_03", tk_log[OVS*9 + OVS/2], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL take parameters: NB_DATA, default 8, data bits per frame; SB_TICK, default 16, baud ticks per stop bit; OVS, default 16, baud ticks per start/data/parity bit.
REQ-002 The block SHALL use reset i_reset, synchronous, active-high, and clock i_clock.
REQ-003 The block SHALL have these ports:
- i_clock  in  1  system clock
- i_reset  in  1  sync reset
- i_tick  in  1  one-cycle baud-rate tick from the baud generator
- i_tx_start  in  1  request to send; sampled only in IDLE
- i_tx_data  in  NB_DATA  byte to send, latched on accept
- o_tx  out  1  serial line, idle high, registered
- o_tx_busy  out  1  high whenever state is not IDLE
- o_tx_done  out  1  one-clock pulse at frame end

Function
REQ-004 The FSM SHALL have states IDLE, START, DATA, PARITY (configured only) and STOP.
REQ-005 In IDLE, i_tx_start=1 SHALL latch i_tx_data into a shift register, clear the tick and bit counters, and enter START on the next edge, independent of i_tick.
REQ-006 The block SHALL ignore i_tx_start outside IDLE; the latched data SHALL NOT change mid-frame.
REQ-007 The tick counter SHALL advance only on cycles with i_tick=1; cycles without i_tick SHALL hold all counters and o_tx.
REQ-008 START SHALL drive o_tx=0 for OVS ticks; on the OVS-th tick it SHALL go to DATA with bit index 0.
REQ-009 DATA SHALL drive LSB-first, one bit per OVS ticks, shifting right on each bit's last tick; after bit NB_DATA-1 it SHALL go to PARITY or STOP.
REQ-010 STOP SHALL drive o_tx=1 for SB_TICK ticks, then return to IDLE.
REQ-011 o_tx_done SHALL be registered and high for exactly the first IDLE cycle after STOP.
REQ-012 An i_tx_start in that same cycle SHALL be accepted, giving back-to-back frames with no idle bit.
REQ-013 o_tx SHALL be a flop output with no combinational glitches; o_tx_busy SHALL be decoded from the state register.
REQ-014 The bit counter SHALL be ceil(log2(NB_DATA)) bits wide and the tick counter ceil(log2(max(OVS,SB_TICK))) bits wide; neither SHALL wrap within a state.
REQ-015 A frame SHALL last exactly (1+NB_DATA+P)*OVS+SB_TICK ticks, where P=1 with parity and 0 without.

Reset
REQ-016 On reset the block SHALL set state IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, and clear the counters and shift register.
REQ-017 Reset mid-frame SHALL abort the frame, return o_tx high at the next edge and emit no o_tx_done.

Configuration
REQ-018 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL drive the even-parity bit (XOR of the latched data) for OVS ticks between DATA and STOP.
REQ-019 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-020 A shared package SHALL hold the state encoding constants (IDLE, START, DATA, PARITY, STOP) and default NB_DATA/OVS/SB_TICK values, shared with the UART RX block.
REQ-021 The sub-module baud_gen SHALL be the natural companion, a modulo-N counter producing i_tick; it SHALL be instantiated outside uart_tx so RX and TX share one tick.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- i_tick every 4 clocks, start with 0xA5, no parity -> o_tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 64 clocks; o_tx_done once, 640 clocks after accept.
- Start pulsed again 100 clocks into a 0x3C frame with data 0xFF -> ignored; 0x3C transmitted intact; a single o_tx_done.
- Start with 0x55 held in the o_tx_done cycle after a 0x0F frame -> START begins the next edge; no extra high bit between frames.
- Reset asserted during DATA bit 3 of 0x81 -> o_tx=1 and busy=0 the next edge; no o_tx_done; a following 0x81 frame is correct.
- UART_TX_PARITY_EN with 0x07 -> parity bit 1; with 0x03 -> parity bit 0; frame length 11*OVS ticks.
- i_tick held low for 50 clocks mid-bit -> o_tx and counters frozen; the frame resumes with exact bit widths in ticks.
